progbufscan: RTL
================

# progbufscan

Debug Module-side serializer that writes words into the core's debug program buffer over the serial scan link. It accepts 32-bit program-buffer writes from the DMI register decode and shifts each word out LSB-first on `ScanOut` while holding `Scan` high for exactly 32 cycles. It then holds `ScanAddr` through the commit cycle in which the buffer latches the word. It also performs a whole-buffer clear that fills every slot with `ebreak`.

## Interface
- `P` — cvw_t configuration, no default. Uses `P.XLEN` and `P.PROGBUF_RANGE`.
- Derived: `PROGBUF_SIZE = (P.PROGBUF_RANGE+1)/4`, which must be a power of two. `ADDR_WIDTH = $clog2(PROGBUF_SIZE)`.

Ports (clock and reset first):
- `clk` — in, 1: sole clock.
- `reset` — in, 1: synchronous, active-high.
- `WriteValid` — in, 1: write request.
- `WriteIndex` — in, ADDR_WIDTH: target word slot.
- `WriteData` — in, 32: word to store.
- `WriteReady` — out, 1: request accepted when `WriteValid & WriteReady` on a rising edge.
- `ClearReq` — in, 1: single-cycle pulse requesting a fill of all slots with `32'h00100073`.
- `Busy` — out, 1: a shift, commit, held write or clear is outstanding.
- `Done` — out, 1: one-cycle pulse in each commit cycle.
- `Scan` — out, 1: shift enable to the program buffer.
- `ScanOut` — out, 1: serial data to the program buffer's scan input.
- `ScanAddr` — out, P.XLEN: slot index, zero-extended.

## Operation
- The receiver shifts right on each `Scan` cycle, inserting at bit 31, so the first bit sent lands at bit 0. Transmission is therefore LSB-first.
- The receiver writes in the first cycle with `Scan`=0 after a `Scan`=1 cycle, using `ScanAddr` as sampled in that cycle.

State machine (state register plus a 5-bit bit counter):
- **IDLE**
  - `Scan`=0.
  - On accept, load the shift register and address, then go to SHIFT.
  - If a held word is valid, load it instead.
- **SHIFT**
  - `Scan`=1. `ScanOut` = shift register bit 0. Shift right each cycle.
  - Counter runs 0..31. At 31, go to COMMIT.
- **COMMIT**
  - `Scan`=0. `ScanAddr` holds the slot index. `Done`=1.
  - If a held word or the next clear slot exists, go to SHIFT with it loaded. Otherwise go to IDLE.

Holding register:
- One-deep holding register (word + index).
- `WriteReady = ~Clearing & ~HoldValid & ~ClearReq`.
- A write accepted in IDLE goes straight to the shifter.
- A write accepted while busy goes to the holding register.

Clear:
- `ClearReq` sets `Clearing` and an index counter at 0.
- Each slot is sent in turn with data `00100073`.
- `Clearing` drops at the COMMIT of slot `PROGBUF_SIZE-1`.
- A held write present when `ClearReq` arrives is sent first, then the clear runs.
- `ClearReq` during `Clearing` is ignored.

Priority and outputs:
- When `ClearReq` and `WriteValid` coincide, clear wins and the write is not accepted.
- `Busy = (state≠IDLE) | HoldValid | Clearing`.
- All outputs are registered.
- `ScanAddr` and `ScanOut` are don't-care while `Scan`=0, except for `ScanAddr` in COMMIT.

## Timing
- **Reset values:** state IDLE, `Scan`=0, `ScanOut`=0, `ScanAddr`=0, `Done`=0, `Busy`=0, `WriteReady`=1. Holding register and clear state are invalid.
- **Reset mid-shift:** abort without a commit cycle. The receiver's scan-history flop is also reset, so no partial word is written.
- **Single write:** accept edge t, then:
  - `Scan`=1 in cycles t+1..t+32, carrying bit k in cycle t+1+k;
  - COMMIT with `Done` in cycle t+33;
  - IDLE with `Busy`=0 at t+34.
- **Back-to-back:** 33-cycle period, with `Scan` low for exactly one cycle between words.
- **Full clear:** `33*PROGBUF_SIZE` cycles from the cycle after `ClearReq`, or 33 more if a held word goes first.
- `ScanAddr` never changes between the first SHIFT cycle and COMMIT inclusive.

## Structure
- Add constant `PROGBUF_FILL = 32'h00100073` to the shared debug package, alongside a typedef for the state enum (IDLE, SHIFT, COMMIT).
- One sub-module is natural: `progbufshiftreg`, a 32-bit parallel-load, shift-right register with a serial output.
- Counters and the holding register use the existing `flopenr`/`flopr` primitives.

## Test plan
1. Reset, write index 3 with `DEADBEEF`:
   - `Scan` high for exactly 32 cycles;
   - serial stream `1,1,1,1,0,1,1,1,…` (LSB-first);
   - the receiver model's slot 3 reads `DEADBEEF` after `Done`; `Busy` low at t+34.
2. Three writes presented continuously (`00000013`→0, `00100073`→1, `FFFFFFFF`→2):
   - `WriteReady` drops while the holding register is full;
   - commits 33 cycles apart;
   - all three slots correct in the model.
3. `ClearReq` with `PROGBUF_SIZE`=16:
   - 16 `Done` pulses;
   - every slot reads `00100073`;
   - `WriteReady`=0 throughout;
   - `Busy` falls `33*16` cycles after the request.
4. `ClearReq` and `WriteValid` in the same cycle:
   - the write is not accepted;
   - after the clear, presenting the write again succeeds.
5. Assert `reset` at bit 17 of a shift:
   - `Scan` is 0 the next cycle;
   - the model's RAM is unchanged;
   - outputs are at their reset values.
6. Write issued while the clear's held-write path is active:
   - the held word commits before slot 0 of the clear;
   - the final state is all `00100073`.

Source files
------------

// File: rtl/progbufscan_pkg.sv
// Shared debug-module definitions for the program-buffer scan serializer.
package progbufscan_pkg;

    // Core configuration subset consumed by the debug module.
    typedef struct packed {
        int XLEN;
        int PROGBUF_RANGE;
    } cvw_t;

    // 16-slot program buffer on a 64-bit core.
    localparam cvw_t PROGBUF_DEFAULT_CFG = '{XLEN: 64, PROGBUF_RANGE: 63};

    // ebreak: every slot holds this after a whole-buffer clear.
    localparam logic [31:0] PROGBUF_FILL = 32'h00100073;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } progbuf_state_t;

endpackage

// File: rtl/flopenr.sv
// Resettable register primitive with load enable.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Synchronous clear, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/flopr.sv
// Resettable register primitive.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Synchronous clear, otherwise load every cycle.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/progbufshiftreg.sv
// 32-bit parallel-load shift-right register; bit 0 is the serial output.
module progbufshiftreg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [31:0] data_i,
    output logic        sout_o
);

    logic [31:0] sr_q;

    // Load has priority over shift; the two never coincide in practice.
    always_ff @(posedge clk) begin
        if (reset)        sr_q <= '0;
        else if (load_i)  sr_q <= data_i;
        else if (shift_i) sr_q <= {1'b0, sr_q[31:1]};
    end

    assign sout_o = sr_q[0];

endmodule

// File: rtl/progbufscan.sv
// Serializes program-buffer writes (and whole-buffer ebreak fills) onto the
// debug scan link: 32 LSB-first Scan cycles, then one commit cycle with
// ScanAddr held so the buffer latches the word.
//
// state  | meaning
// IDLE   | nothing in flight, Scan low
// SHIFT  | Scan high, one bit per cycle, bit counter 0..31
// COMMIT | Scan low, ScanAddr held, Done pulsed; receiver latches the word
module progbufscan
    import progbufscan_pkg::*;
#(
    parameter cvw_t P = PROGBUF_DEFAULT_CFG,
    localparam int PROGBUF_SIZE = (P.PROGBUF_RANGE + 1) / 4,
    localparam int ADDR_WIDTH   = $clog2(PROGBUF_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WriteValid,
    input  logic [ADDR_WIDTH-1:0] WriteIndex,
    input  logic [31:0]           WriteData,
    output logic                  WriteReady,
    input  logic                  ClearReq,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Scan,
    output logic                  ScanOut,
    output logic [P.XLEN-1:0]     ScanAddr
);

    localparam int XLEN  = P.XLEN;
    // One extra bit so "all slots dispatched" is representable.
    localparam int CNT_W = ADDR_WIDTH + 1;

    progbuf_state_t        state_q, state_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  scan_q, done_q, busy_q, ready_q;
    logic                  ready_d, busy_d;

    logic                  hold_valid_q, hold_valid_d, hold_set, hold_clr;
    logic [31:0]           hold_data_q;
    logic [ADDR_WIDTH-1:0] hold_idx_q;

    logic                  clearing_q, clearing_d, clearing_cur;
    logic                  clr_start, clr_more, clr_adv;
    logic [CNT_W-1:0]      clr_idx_q, clr_idx_d, clr_idx_cur;

    logic                  accept, load, shift;
    logic [31:0]           load_data;
    logic [ADDR_WIDTH-1:0] load_idx;

    // A clear request outranks a write presented in the same cycle.
    assign WriteReady = ready_q & ~ClearReq;
    assign accept     = WriteValid & WriteReady;
    assign shift      = (state_q == SHIFT);

    // A new clear restarts the slot counter in the same cycle it arrives, so
    // an idle (or just-committed) shifter can start slot 0 immediately.
    assign clr_start    = ClearReq & ~clearing_q;
    assign clearing_cur = clearing_q | ClearReq;
    assign clr_idx_cur  = clr_start ? '0 : clr_idx_q;
    assign clr_more     = clearing_cur & (clr_idx_cur != CNT_W'(PROGBUF_SIZE));

    // Next-word selection: held write first, then the next clear slot, then a
    // write arriving this cycle; with nothing pending the clear is finished.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_data  = hold_data_q;
        load_idx   = hold_idx_q;
        hold_set   = 1'b0;
        hold_clr   = 1'b0;
        clr_adv    = 1'b0;
        clearing_d = clearing_cur;
        unique case (state_q)
            SHIFT: begin
                hold_set = accept;
                if (bitcnt_q == 5'd31) state_d = COMMIT;
            end
            IDLE, COMMIT: begin
                if (hold_valid_q) begin
                    load     = 1'b1;
                    hold_clr = 1'b1;
                    state_d  = SHIFT;
                end else if (clr_more) begin
                    load      = 1'b1;
                    load_data = PROGBUF_FILL;
                    load_idx  = clr_idx_cur[ADDR_WIDTH-1:0];
                    clr_adv   = 1'b1;
                    state_d   = SHIFT;
                end else if (accept) begin
                    load      = 1'b1;
                    load_data = WriteData;
                    load_idx  = WriteIndex;
                    state_d   = SHIFT;
                end else begin
                    state_d    = IDLE;
                    clearing_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Derived next values for counters, holding flag and registered outputs.
    always_comb begin
        hold_valid_d = hold_set | (hold_valid_q & ~hold_clr);
        clr_idx_d    = clr_idx_cur + {{ADDR_WIDTH{1'b0}}, clr_adv};
        bitcnt_d     = shift ? bitcnt_q + 5'd1 : 5'd0;
        ready_d      = ~clearing_d & ~hold_valid_d;
        busy_d       = (state_d != IDLE) | hold_valid_d | clearing_d;
    end

    // State register and registered outputs; ScanAddr only moves on a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            scan_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) addr_q <= load_idx;
            scan_q  <= (state_d == SHIFT);
            done_q  <= (state_d == COMMIT);
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    flopr   #(.WIDTH(5))          u_bitcnt     (.clk(clk), .reset(reset), .d(bitcnt_d), .q(bitcnt_q));
    flopr   #(.WIDTH(1))          u_hold_valid (.clk(clk), .reset(reset), .d(hold_valid_d), .q(hold_valid_q));
    flopenr #(.WIDTH(32))         u_hold_data  (.clk(clk), .reset(reset), .en(hold_set), .d(WriteData), .q(hold_data_q));
    flopenr #(.WIDTH(ADDR_WIDTH)) u_hold_idx   (.clk(clk), .reset(reset), .en(hold_set), .d(WriteIndex), .q(hold_idx_q));
    flopr   #(.WIDTH(1))          u_clearing   (.clk(clk), .reset(reset), .d(clearing_d), .q(clearing_q));
    flopr   #(.WIDTH(CNT_W))      u_clr_idx    (.clk(clk), .reset(reset), .d(clr_idx_d), .q(clr_idx_q));

    progbufshiftreg u_shiftreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (load_data),
        .sout_o  (ScanOut)
    );

    assign Scan     = scan_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign ScanAddr = XLEN'(addr_q);

endmodule
